// File: rtl/cpu_defs.sv
// Shared definitions for the hardwired control sequencer:
// state codes, bus source codes, opcodes, ALU operations and IR field positions.
package cpu_defs;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned WAIT_W  = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_T0   = 4'd1;
  localparam state_t ST_T1   = 4'd2;
  localparam state_t ST_T2   = 4'd3;
  localparam state_t ST_T3   = 4'd4;
  localparam state_t ST_T4   = 4'd5;
  localparam state_t ST_T5   = 4'd6;
  localparam state_t ST_T6   = 4'd7;
  localparam state_t ST_HALT = 4'd8;

  // Bus sources; 0xxxx selects GP[xxxx]
  localparam logic [4:0] BUS_ZHI = 5'b10010;
  localparam logic [4:0] BUS_ZLO = 5'b10011;
  localparam logic [4:0] BUS_PC  = 5'b10100;
  localparam logic [4:0] BUS_MDR = 5'b10101;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_SHR  = 4'b0101;
  localparam logic [3:0] ALU_SHRA = 4'b0110;
  localparam logic [3:0] ALU_SHL  = 4'b0111;
  localparam logic [3:0] ALU_ROL  = 4'b1001;
  localparam logic [3:0] ALU_ROR  = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1011;
  localparam logic [3:0] ALU_DIV  = 4'b1100;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  typedef enum logic [1:0] {
    CLS_RRR     = 2'd0,
    CLS_MULDIV  = 2'd1,
    CLS_ILLEGAL = 2'd2
  } op_class_e;

  typedef struct packed {
    logic [3:0] alu_op;
    op_class_e  cls;
  } decode_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: maps the 5-bit opcode to an ALU operation and an instruction class.
module instr_decode
  import cpu_defs::*;
(
  input  logic [4:0] i_op,
  output decode_t    o_dec_c
);

  always_comb begin
    o_dec_c.alu_op = ALU_NOP;
    o_dec_c.cls    = CLS_ILLEGAL;
    case (i_op)
      OP_ADD:  begin o_dec_c.alu_op = ALU_ADD;  o_dec_c.cls = CLS_RRR;    end
      OP_SUB:  begin o_dec_c.alu_op = ALU_SUB;  o_dec_c.cls = CLS_RRR;    end
      OP_AND:  begin o_dec_c.alu_op = ALU_AND;  o_dec_c.cls = CLS_RRR;    end
      OP_OR:   begin o_dec_c.alu_op = ALU_OR;   o_dec_c.cls = CLS_RRR;    end
      OP_ROR:  begin o_dec_c.alu_op = ALU_ROR;  o_dec_c.cls = CLS_RRR;    end
      OP_ROL:  begin o_dec_c.alu_op = ALU_ROL;  o_dec_c.cls = CLS_RRR;    end
      OP_SHR:  begin o_dec_c.alu_op = ALU_SHR;  o_dec_c.cls = CLS_RRR;    end
      OP_SHRA: begin o_dec_c.alu_op = ALU_SHRA; o_dec_c.cls = CLS_RRR;    end
      OP_SHL:  begin o_dec_c.alu_op = ALU_SHL;  o_dec_c.cls = CLS_RRR;    end
      OP_MUL:  begin o_dec_c.alu_op = ALU_MUL;  o_dec_c.cls = CLS_MULDIV; end
      OP_DIV:  begin o_dec_c.alu_op = ALU_DIV;  o_dec_c.cls = CLS_MULDIV; end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetches in T0-T2, executes register-register ALU and MUL/DIV in T3-T6.
// Control outputs are a Moore decode of the state register plus IR register fields.
module control_sequencer
  import cpu_defs::*;
#(
  parameter int unsigned MEM_WAIT        = 0,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir_in,
  output logic [4:0]  BusDataSelect,
  output logic [3:0]  GP_addr,
  output logic [3:0]  ALU_op,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_HI,
  output logic        e_LO,
  output logic        e_MDR,
  output logic        e_MAR,
  output logic        e_GP,
  output logic        incPC,
  output logic        MDR_read,
  output logic [3:0]  state_out,
  output logic        done,
  output logic        illegal
);

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              r_illegal;
  op_class_e         r_cls;
  decode_t           w_dec;
  logic [3:0]        w_ra;
  logic [3:0]        w_rb;
  logic [3:0]        w_rc;
  logic              w_unused_ir;

  assign w_ra        = ir_in[RA_MSB:RA_LSB];
  assign w_rb        = ir_in[RB_MSB:RB_LSB];
  assign w_rc        = ir_in[RC_MSB:RC_LSB];
  assign w_unused_ir = ^ir_in[RC_LSB-1:0];

  instr_decode u_decode (
    .i_op    (ir_in[OP_MSB:OP_LSB]),
    .o_dec_c (w_dec)
  );

  // State, T1 wait counter, latched instruction class and sticky illegal flag
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= ST_IDLE;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_cls     <= CLS_RRR;
    end else begin
      r_state <= w_next;
      if (r_state == ST_T1 && w_next == ST_T1) r_wait <= r_wait + WAIT_W'(1);
      else                                     r_wait <= '0;
      if (r_state == ST_T3) begin
        r_cls <= w_dec.cls;
        if (w_dec.cls == CLS_ILLEGAL) r_illegal <= 1'b1;
      end
    end
  end

  assign state_out = r_state;
  assign illegal   = r_illegal;

  // Next-state and control-word decode
  always_comb begin
    w_next        = r_state;
    BusDataSelect = 5'b00000;
    GP_addr       = 4'd0;
    ALU_op        = ALU_NOP;
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_HI          = 1'b0;
    e_LO          = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_GP          = 1'b0;
    incPC         = 1'b0;
    MDR_read      = 1'b0;
    done          = 1'b0;
    case (r_state)
      ST_IDLE: if (run) w_next = ST_T0;
      ST_T0: begin
        BusDataSelect = BUS_PC;
        e_MAR         = 1'b1;
        incPC         = 1'b1;
        e_Z           = 1'b1;
        w_next        = ST_T1;
      end
      ST_T1: begin
        BusDataSelect = BUS_ZLO;
        e_PC          = 1'b1;
        MDR_read      = 1'b1;
        e_MDR         = 1'b1;
        if (r_wait == WAIT_W'(MEM_WAIT)) w_next = ST_T2;
      end
      ST_T2: begin
        BusDataSelect = BUS_MDR;
        e_IR          = 1'b1;
        w_next        = ST_T3;
      end
      ST_T3: begin
        // MUL/DIV latch Ra first so Rb can follow straight into the ALU
        BusDataSelect = (w_dec.cls == CLS_MULDIV) ? {1'b0, w_ra} : {1'b0, w_rb};
        e_Y           = 1'b1;
        if (w_dec.cls == CLS_ILLEGAL) w_next = HALT_ON_ILLEGAL ? ST_HALT : ST_IDLE;
        else                          w_next = ST_T4;
      end
      ST_T4: begin
        BusDataSelect = (r_cls == CLS_MULDIV) ? {1'b0, w_rb} : {1'b0, w_rc};
        ALU_op        = w_dec.alu_op;
        e_Z           = 1'b1;
        w_next        = ST_T5;
      end
      ST_T5: begin
        BusDataSelect = BUS_ZLO;
        if (r_cls == CLS_MULDIV) begin
          e_LO   = 1'b1;
          w_next = ST_T6;
        end else begin
          GP_addr = w_ra;
          e_GP    = 1'b1;
          done    = 1'b1;
          w_next  = run ? ST_T0 : ST_IDLE;
        end
      end
      ST_T6: begin
        BusDataSelect = BUS_ZHI;
        e_HI          = 1'b1;
        done          = 1'b1;
        w_next        = run ? ST_T0 : ST_IDLE;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected control words are queued, then
// popped and compared one cycle at a time. Two instances cover MEM_WAIT=0 and MEM_WAIT=2.
module tb_control_sequencer;

  typedef logic [29:0] vec_t;  // {state,bus,gp,alu,en[10:0],done,illegal}
  typedef struct packed {
    vec_t exp;
    vec_t mask;
    logic run_nx;
    logic clr_nx;
  } item_t;

  localparam logic [3:0] S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4;
  localparam logic [3:0] S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8;

  // enable order: e_PC,e_IR,e_Y,e_Z,e_HI,e_LO,e_MDR,e_MAR,e_GP,incPC,MDR_read
  localparam logic [10:0] EN_PC = 11'h400, EN_IR = 11'h200, EN_Y = 11'h100, EN_Z = 11'h080;
  localparam logic [10:0] EN_HI = 11'h040, EN_LO = 11'h020, EN_MDR = 11'h010, EN_MAR = 11'h008;
  localparam logic [10:0] EN_GP = 11'h004, EN_INC = 11'h002, EN_MRD = 11'h001, EN_NONE = 11'h000;

  localparam vec_t M_ALL   = '1;
  localparam vec_t M_NOALU = ~(vec_t'(4'hF) << 13);
  localparam vec_t M_NOGP  = ~(vec_t'(4'hF) << 17);
  localparam vec_t M_NOGA  = M_NOALU & M_NOGP;
  localparam vec_t M_HALT  = M_NOGA & ~(vec_t'(5'h1F) << 21);

  logic        clock = 1'b0;
  logic        clear;
  logic        run;
  logic [31:0] ir_in;

  logic [4:0] a_bus, b_bus;
  logic [3:0] a_gp, b_gp, a_alu, b_alu, a_st, b_st;
  logic a_pc, a_ir, a_y, a_z, a_hi, a_lo, a_mdr, a_mar, a_egp, a_inc, a_mrd, a_done, a_ill;
  logic b_pc, b_ir, b_y, b_z, b_hi, b_lo, b_mdr, b_mar, b_egp, b_inc, b_mrd, b_done, b_ill;

  item_t sb_q[$];
  int    n_total = 0;
  int    n_pass  = 0;

  always #5 clock = ~clock;

  control_sequencer #(.MEM_WAIT(0), .HALT_ON_ILLEGAL(1'b1)) u_dut (
    .clock(clock), .clear(clear), .run(run), .ir_in(ir_in),
    .BusDataSelect(a_bus), .GP_addr(a_gp), .ALU_op(a_alu),
    .e_PC(a_pc), .e_IR(a_ir), .e_Y(a_y), .e_Z(a_z), .e_HI(a_hi), .e_LO(a_lo),
    .e_MDR(a_mdr), .e_MAR(a_mar), .e_GP(a_egp), .incPC(a_inc), .MDR_read(a_mrd),
    .state_out(a_st), .done(a_done), .illegal(a_ill)
  );

  control_sequencer #(.MEM_WAIT(2), .HALT_ON_ILLEGAL(1'b1)) u_dut_w (
    .clock(clock), .clear(clear), .run(run), .ir_in(ir_in),
    .BusDataSelect(b_bus), .GP_addr(b_gp), .ALU_op(b_alu),
    .e_PC(b_pc), .e_IR(b_ir), .e_Y(b_y), .e_Z(b_z), .e_HI(b_hi), .e_LO(b_lo),
    .e_MDR(b_mdr), .e_MAR(b_mar), .e_GP(b_egp), .incPC(b_inc), .MDR_read(b_mrd),
    .state_out(b_st), .done(b_done), .illegal(b_ill)
  );

  function automatic vec_t observe(bit w);
    if (w) return {b_st, b_bus, b_gp, b_alu,
                   b_pc, b_ir, b_y, b_z, b_hi, b_lo, b_mdr, b_mar, b_egp, b_inc, b_mrd, b_done, b_ill};
    return {a_st, a_bus, a_gp, a_alu,
            a_pc, a_ir, a_y, a_z, a_hi, a_lo, a_mdr, a_mar, a_egp, a_inc, a_mrd, a_done, a_ill};
  endfunction

  function automatic void push(logic [3:0] st, logic [4:0] bus, logic [3:0] gp, logic [3:0] alu,
                               logic [10:0] en, logic dn, logic il, vec_t m, logic rn, logic cl);
    item_t it;
    it.exp    = {st, bus, gp, alu, en, dn, il};
    it.mask   = m;
    it.run_nx = rn;
    it.clr_nx = cl;
    sb_q.push_back(it);
  endfunction

  function automatic void push_fetch(int unsigned waits, logic rn);
    push(S_T0, 5'b10100, 4'd0, 4'd0, EN_MAR | EN_INC | EN_Z, 1'b0, 1'b0, M_NOGA, rn, 1'b0);
    for (int unsigned i = 0; i <= waits; i++)
      push(S_T1, 5'b10011, 4'd0, 4'd0, EN_PC | EN_MRD | EN_MDR, 1'b0, 1'b0, M_NOGA, rn, 1'b0);
    push(S_T2, 5'b10101, 4'd0, 4'd0, EN_IR, 1'b0, 1'b0, M_NOGA, rn, 1'b0);
  endfunction

  task automatic do_clear();
    clear = 1'b1;
    run   = 1'b0;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    vec_t got;
    int   k = 0;
    @(posedge clock); #1;
    got = observe(1'b0);
    n_total++;
    if (got !== vec_t'(0)) $display("FAIL reset_a: got %h want %h", got, vec_t'(0));
    else n_pass++;
    got = observe(1'b1);
    n_total++;
    if (got !== vec_t'(0)) $display("FAIL reset_w: got %h want %h", got, vec_t'(0));
    else n_pass++;
    clear = 1'b0;
    push(S_IDLE, 5'd0, 4'd0, 4'd0, EN_NONE, 1'b0, 1'b0, M_ALL, 1'b0, 1'b0);
    push(S_IDLE, 5'd0, 4'd0, 4'd0, EN_NONE, 1'b0, 1'b0, M_ALL, 1'b0, 1'b0);
    while (sb_q.size() != 0) begin
      item_t it;
      @(posedge clock); #1;
      it  = sb_q.pop_front();
      got = observe(1'b0) & it.mask;
      n_total++;
      if (got !== (it.exp & it.mask)) $display("FAIL idle step %0d: got %h want %h", k, got, it.exp & it.mask);
      else n_pass++;
      run = it.run_nx; clear = it.clr_nx; k++;
    end
  endtask

  task automatic test_ror();
    vec_t got;
    int   k = 0;
    do_clear();
    ir_in = 32'h3A1B8000;  // ROR R4,R3,R7
    run   = 1'b1;
    push_fetch(0, 1'b0);
    push(S_T3, 5'b00011, 4'd0, 4'd0, EN_Y, 1'b0, 1'b0, M_NOGA, 1'b0, 1'b0);
    push(S_T4, 5'b00111, 4'd0, 4'b1010, EN_Z, 1'b0, 1'b0, M_NOGP, 1'b0, 1'b0);
    push(S_T5, 5'b10011, 4'd4, 4'd0, EN_GP, 1'b1, 1'b0, M_NOALU, 1'b0, 1'b0);
    push(S_IDLE, 5'd0, 4'd0, 4'd0, EN_NONE, 1'b0, 1'b0, M_ALL, 1'b0, 1'b0);
    while (sb_q.size() != 0) begin
      item_t it;
      @(posedge clock); #1;
      it  = sb_q.pop_front();
      got = observe(1'b0) & it.mask;
      n_total++;
      if (got !== (it.exp & it.mask)) $display("FAIL ror step %0d: got %h want %h", k, got, it.exp & it.mask);
      else n_pass++;
      run = it.run_nx; clear = it.clr_nx; k++;
    end
  endtask

  task automatic test_muldiv();
    vec_t got;
    int   k = 0;
    do_clear();
    ir_in = 32'h79280000;  // MUL R2,R5
    run   = 1'b1;
    push_fetch(0, 1'b0);
    push(S_T3, 5'b00010, 4'd0, 4'd0, EN_Y, 1'b0, 1'b0, M_NOGA, 1'b0, 1'b0);
    push(S_T4, 5'b00101, 4'd0, 4'd0, EN_Z, 1'b0, 1'b0, M_NOGA, 1'b0, 1'b0);
    push(S_T5, 5'b10011, 4'd0, 4'd0, EN_LO, 1'b0, 1'b0, M_NOGA, 1'b0, 1'b0);
    push(S_T6, 5'b10010, 4'd0, 4'd0, EN_HI, 1'b1, 1'b0, M_NOGA, 1'b0, 1'b0);
    push(S_IDLE, 5'd0, 4'd0, 4'd0, EN_NONE, 1'b0, 1'b0, M_ALL, 1'b0, 1'b0);
    while (sb_q.size() != 0) begin
      item_t it;
      @(posedge clock); #1;
      it  = sb_q.pop_front();
      got = observe(1'b0) & it.mask;
      n_total++;
      if (got !== (it.exp & it.mask)) $display("FAIL mul step %0d: got %h want %h", k, got, it.exp & it.mask);
      else n_pass++;
      run = it.run_nx; clear = it.clr_nx; k++;
    end
  endtask

  task automatic test_mem_wait();
    vec_t got;
    int   k = 0;
    do_clear();
    ir_in = 32'h18918000;  // ADD R1,R2,R3
    run   = 1'b1;
    push_fetch(2, 1'b0);
    push(S_T3, 5'b00010, 4'd0, 4'd0, EN_Y, 1'b0, 1'b0, M_NOGA, 1'b0, 1'b0);
    push(S_T4, 5'b00011, 4'd0, 4'd0, EN_Z, 1'b0, 1'b0, M_NOGA, 1'b0, 1'b0);
    push(S_T5, 5'b10011, 4'd1, 4'd0, EN_GP, 1'b1, 1'b0, M_NOALU, 1'b0, 1'b0);
    push(S_IDLE, 5'd0, 4'd0, 4'd0, EN_NONE, 1'b0, 1'b0, M_ALL, 1'b0, 1'b0);
    while (sb_q.size() != 0) begin
      item_t it;
      @(posedge clock); #1;
      it  = sb_q.pop_front();
      got = observe(1'b1) & it.mask;
      n_total++;
      if (got !== (it.exp & it.mask)) $display("FAIL memwait step %0d: got %h want %h", k, got, it.exp & it.mask);
      else n_pass++;
      run = it.run_nx; clear = it.clr_nx; k++;
    end
  endtask

  task automatic test_illegal();
    vec_t got;
    int   k = 0;
    do_clear();
    ir_in = 32'hF8000000;  // opcode 11111
    run   = 1'b1;
    push_fetch(0, 1'b1);
    push(S_T3, 5'b00000, 4'd0, 4'd0, EN_Y, 1'b0, 1'b0, M_NOGA, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      push(S_HALT, 5'd0, 4'd0, 4'd0, EN_NONE, 1'b0, 1'b1, M_HALT, 1'b1, (i == 9));
    push(S_IDLE, 5'd0, 4'd0, 4'd0, EN_NONE, 1'b0, 1'b0, M_ALL, 1'b1, 1'b0);
    push(S_T0, 5'b10100, 4'd0, 4'd0, EN_MAR | EN_INC | EN_Z, 1'b0, 1'b0, M_NOGA, 1'b0, 1'b0);
    while (sb_q.size() != 0) begin
      item_t it;
      @(posedge clock); #1;
      it  = sb_q.pop_front();
      got = observe(1'b0) & it.mask;
      n_total++;
      if (got !== (it.exp & it.mask)) $display("FAIL illegal step %0d: got %h want %h", k, got, it.exp & it.mask);
      else n_pass++;
      run = it.run_nx; clear = it.clr_nx; k++;
    end
  endtask

  task automatic test_clear_mid();
    vec_t got;
    int   k = 0;
    do_clear();
    ir_in = 32'h22B38000;  // SUB R5,R6,R7
    run   = 1'b1;
    push_fetch(0, 1'b1);
    push(S_T3, 5'b00110, 4'd0, 4'd0, EN_Y, 1'b0, 1'b0, M_NOGA, 1'b1, 1'b0);
    push(S_T4, 5'b00111, 4'd0, 4'd0, EN_Z, 1'b0, 1'b0, M_NOGA, 1'b1, 1'b1);
    push(S_IDLE, 5'd0, 4'd0, 4'd0, EN_NONE, 1'b0, 1'b0, M_ALL, 1'b1, 1'b0);
    push(S_T0, 5'b10100, 4'd0, 4'd0, EN_MAR | EN_INC | EN_Z, 1'b0, 1'b0, M_NOGA, 1'b0, 1'b0);
    while (sb_q.size() != 0) begin
      item_t it;
      @(posedge clock); #1;
      it  = sb_q.pop_front();
      got = observe(1'b0) & it.mask;
      n_total++;
      if (got !== (it.exp & it.mask)) $display("FAIL clear step %0d: got %h want %h", k, got, it.exp & it.mask);
      else n_pass++;
      run = it.run_nx; clear = it.clr_nx; k++;
    end
  endtask

  task automatic test_back_to_back();
    vec_t got;
    int   k = 0;
    do_clear();
    ir_in = 32'h18918000;  // ADD R1,R2,R3
    run   = 1'b1;
    push_fetch(0, 1'b1);
    push(S_T3, 5'b00010, 4'd0, 4'd0, EN_Y, 1'b0, 1'b0, M_NOGA, 1'b1, 1'b0);
    push(S_T4, 5'b00011, 4'd0, 4'd0, EN_Z, 1'b0, 1'b0, M_NOGA, 1'b1, 1'b0);
    push(S_T5, 5'b10011, 4'd1, 4'd0, EN_GP, 1'b1, 1'b0, M_NOALU, 1'b1, 1'b0);
    push_fetch(0, 1'b1);
    push(S_T3, 5'b00010, 4'd0, 4'd0, EN_Y, 1'b0, 1'b0, M_NOGA, 1'b0, 1'b0);
    push(S_T4, 5'b00011, 4'd0, 4'd0, EN_Z, 1'b0, 1'b0, M_NOGA, 1'b0, 1'b0);
    push(S_T5, 5'b10011, 4'd1, 4'd0, EN_GP, 1'b1, 1'b0, M_NOALU, 1'b0, 1'b0);
    push(S_IDLE, 5'd0, 4'd0, 4'd0, EN_NONE, 1'b0, 1'b0, M_ALL, 1'b0, 1'b0);
    push(S_IDLE, 5'd0, 4'd0, 4'd0, EN_NONE, 1'b0, 1'b0, M_ALL, 1'b0, 1'b0);
    while (sb_q.size() != 0) begin
      item_t it;
      @(posedge clock); #1;
      it  = sb_q.pop_front();
      got = observe(1'b0) & it.mask;
      n_total++;
      if (got !== (it.exp & it.mask)) $display("FAIL b2b step %0d: got %h want %h", k, got, it.exp & it.mask);
      else n_pass++;
      run = it.run_nx; clear = it.clr_nx; k++;
    end
  endtask

  initial begin
    clear = 1'b1;
    run   = 1'b0;
    ir_in = 32'h0;
    test_reset();
    test_ror();
    test_muldiv();
    test_mem_wait();
    test_illegal();
    test_clear_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
